// File: rtl/echo_ram_sequencer_pkg.sv
// echo_ram_sequencer_pkg: shared sizes and FSM encoding for the echo delay-RAM sequencer
package echo_ram_sequencer_pkg;
    localparam int NTAPS_DEF  = 3;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 10;
    localparam int ACC_W      = 13;
    localparam int SW_W       = 10;
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_DRAIN, S_WRITE} state_t;
endpackage

// File: rtl/echo_ram_sequencer_strobe_sync.sv
// echo_ram_sequencer_strobe_sync: 2-FF synchroniser plus rising-edge detect for the ADC strobe
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_level  asynchronous level input
//   o_pulse  one-cycle pulse per synchronised rising edge
module echo_ram_sequencer_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);
    logic [2:0] r_sh;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sh <= '0;
        else r_sh <= {r_sh[1:0], i_level};
    end
    assign o_pulse = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/echo_ram_sequencer.sv
// echo_ram_sequencer: per-sample delay-RAM tap reads, feedback write-back and saturated echo output
//   sysclk, rst_n         clock, asynchronous active-low reset
//   data_valid, x_in      ADC sample-ready level (async) and input sample
//   delay_sw              base delay in units of 8 samples
//   ram_addr/wdata/we     delay RAM request, ram_rdata returns one cycle after ram_addr
//   y_out, y_valid        processed sample and its update pulse
//   busy, overrun         not-idle flag, sticky strobe-while-busy flag
module echo_ram_sequencer
    import echo_ram_sequencer_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [SW_W-1:0]   delay_sw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-2:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-2:0] ram_rdata,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    output logic              busy,
    output logic              overrun
);
    localparam logic [1:0] LAST_TAP = 2'(NTAPS - 1);
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W:0] Y_MIN = ~Y_MAX;
    state_t                   r_state, w_next;
    logic [ADDR_W-1:0]        r_clr_addr, r_wr_ptr, r_off, w_base;
    logic [DATA_W-1:0]        r_x, r_y, w_y;
    logic [SW_W-1:0]          r_dly;
    logic [1:0]               r_tap, r_rd_k;
    logic                     r_rd_v, r_y_valid, r_overrun, w_strobe;
    logic signed [ACC_W-1:0]  r_acc, w_tap;
    logic signed [ACC_W:0]    w_diff;

    echo_ram_sequencer_strobe_sync u_sync (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_level (data_valid),
        .o_pulse (w_strobe)
    );

    assign w_base = ADDR_W'({r_dly, 3'b000});
    assign w_tap  = {{(ACC_W - DATA_W + 1){ram_rdata[DATA_W-2]}}, ram_rdata};
    assign w_diff = {{(ACC_W + 1 - DATA_W){r_x[DATA_W-1]}}, r_x} - {r_acc[ACC_W-1], r_acc};
    assign w_y    = (w_diff > Y_MAX) ? Y_MAX[DATA_W-1:0] :
                    (w_diff < Y_MIN) ? Y_MIN[DATA_W-1:0] : w_diff[DATA_W-1:0];

    // r_off holds (k+1)*B for the tap being read, so the address is a plain subtract
    assign ram_addr  = (r_state == S_CLEAR) ? r_clr_addr :
                       (r_state == S_READ)  ? r_wr_ptr - r_off : r_wr_ptr;
    assign ram_wdata = (r_state == S_WRITE) ? w_y[DATA_W-1:1] : '0;
    // the FSM rests in CLEAR while reset is held; keep the RAM from being written then
    assign ram_we    = rst_n & ((r_state == S_CLEAR) | (r_state == S_WRITE));
    assign y_out     = r_y;
    assign y_valid   = r_y_valid;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: w_next = &r_clr_addr ? S_IDLE : S_CLEAR;
            S_IDLE:  w_next = w_strobe ? S_READ : S_IDLE;
            S_READ:  w_next = (r_tap == LAST_TAP) ? S_DRAIN : S_READ;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_off      <= '0;
            r_x        <= '0;
            r_dly      <= '0;
            r_tap      <= '0;
            r_rd_k     <= '0;
            r_rd_v     <= 1'b0;
            r_acc      <= '0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_y_valid <= 1'b0;
            r_rd_v    <= 1'b0;
            // read data lags its address by one cycle, so it is tagged with the previous tap index
            if (r_rd_v) r_acc <= r_acc + (w_tap >>> r_rd_k);
            if (w_strobe && r_state != S_IDLE && r_state != S_CLEAR) r_overrun <= 1'b1;
            if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            if (r_state == S_IDLE && w_strobe) begin
                r_x   <= x_in;
                r_dly <= delay_sw;
                r_off <= ADDR_W'({delay_sw, 3'b000});
                r_acc <= '0;
                r_tap <= '0;
            end
            if (r_state == S_READ) begin
                r_tap  <= r_tap + 1'b1;
                r_off  <= r_off + w_base;
                r_rd_k <= r_tap;
                r_rd_v <= |r_dly;
            end
            if (r_state == S_WRITE) begin
                r_y       <= w_y;
                r_y_valid <= 1'b1;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_echo_ram_sequencer.sv
// tb_echo_ram_sequencer: directed bench with a delay-RAM model and an output scoreboard
module tb_echo_ram_sequencer;
    logic        sysclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        data_valid = 1'b0;
    logic [9:0]  x_in = '0;
    logic [9:0]  delay_sw = '0;
    logic [12:0] ram_addr;
    logic [8:0]  ram_wdata;
    logic        ram_we;
    logic [8:0]  ram_rdata;
    logic [9:0]  y_out;
    logic        y_valid, busy, overrun;

    int vecs = 0;
    int errs = 0;

    logic [8:0]        ram   [8192];
    logic [8:0]        m_mem [8192];
    logic [12:0]       m_wp = '0;
    logic signed [9:0] q [$];

    echo_ram_sequencer dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .x_in       (x_in),
        .delay_sw   (delay_sw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // reference: y = sat(x - sum(tap_k >>> k)), RAM keeps y[9:1]
    task automatic model_step(input logic signed [9:0] x, input logic [9:0] sw);
        logic [12:0] b, a;
        logic signed [12:0] acc, t;
        logic signed [13:0] d;
        logic signed [9:0] y;
        b = {sw, 3'b000};
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            if (b != 0) begin
                a = m_wp - 13'(k + 1) * b;
                t = {{4{m_mem[a][8]}}, m_mem[a]};
                acc = acc + (t >>> k);
            end
        end
        d = {{4{x[9]}}, x} - {acc[12], acc};
        y = (d > 511) ? 10'h1FF : (d < -512) ? 10'h200 : d[9:0];
        m_mem[m_wp] = y[9:1];
        m_wp = m_wp + 1'b1;
        q.push_back(y);
    endtask

    always @(negedge sysclk) begin
        if (rst_n && y_valid) begin
            vecs++;
            assert (q.size() > 0) else begin
                errs++;
                $error("FAIL y_extra: observed y_valid with %0d queued expected %0d", q.size(), 1);
            end
            if (q.size() > 0) chk("y_out", $signed(y_out), q.pop_front());
        end
    end

    // one checked sample: strobe latency, tap addresses, write cycle, y_valid pulse
    task automatic sample(input logic signed [9:0] x, input logic [9:0] sw);
        logic [12:0] wp0, b, ea;
        int n;
        wp0 = m_wp;
        b = {sw, 3'b000};
        model_step(x, sw);
        x_in = x;
        delay_sw = sw;
        data_valid = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        chk("strobe_latency", n, 3);
        data_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ea = wp0 - 13'(k + 1) * b;
            if (sw != 0) chk("tap_addr", ram_addr, ea);
            @(negedge sysclk);
        end
        @(negedge sysclk);
        chk("write_we", ram_we, 1);
        chk("write_addr", ram_addr, wp0);
        @(negedge sysclk);
        chk("y_valid", y_valid, 1);
        @(negedge sysclk);
        chk("y_pulse", y_valid, 0);
        tick(1);
    endtask

    task automatic fast(input logic signed [9:0] x);
        model_step(x, 10'd0);
        x_in = x;
        delay_sw = '0;
        data_valid = 1'b1;
        tick(3);
        data_valid = 1'b0;
        tick(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wp;
        for (int i = 0; i < 8192; i++) begin
            ram[i] = 9'h1AA;
            m_mem[i] = '0;
        end
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        #1;
        n = 0;
        while (busy && n < 9000) begin
            chk("clear_cycle", {ram_we, ram_wdata, ram_addr}, {1'b1, 9'd0, 13'(n)});
            @(negedge sysclk);
            n++;
        end
        chk("clear_len", n, 8192);
        tick(2);

        sample(10'sd100, 10'd0);
        chk("bypass_y", $signed(y_out), 100);
        chk("bypass_ram0", ram[0], 50);

        sample(10'sd200, 10'd1);
        for (int i = 1; i < 100; i++) begin
            sample(10'sd0, 10'd1);
            if (i == 8) chk("impulse8_y", $signed(y_out), -100);
        end

        wp = int'(m_wp);
        for (int k = 1; k <= 3; k++) begin
            ram[13'(wp - 8 * k)] = 9'h0FF;
            m_mem[13'(wp - 8 * k)] = 9'h0FF;
        end
        sample(-10'sd512, 10'd1);
        chk("sat_y", $signed(y_out), -512);
        chk("sat_ram", ram[wp], 9'h100);
        chk("overrun_clean", overrun, 0);

        while (m_wp != 13'd8191) fast(10'($urandom_range(0, 1023)));
        tick(4);
        chk("overrun_after_fill", overrun, 0);
        sample(10'sd40, 10'd1);
        sample(10'sd0, 10'd1);

        x_in = 10'sd77;
        delay_sw = 10'd1;
        model_step(10'sd77, 10'd1);
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        tick(1);
        data_valid = 1'b1;
        tick(12);
        data_valid = 1'b0;
        tick(2);
        chk("overrun_set", overrun, 1);
        sample(10'sd5, 10'd1);
        chk("overrun_sticky", overrun, 1);
        chk("queue_empty", q.size(), 0);

        x_in = 10'sd10;
        delay_sw = 10'd1;
        data_valid = 1'b1;
        tick(4);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_y_out", y_out, 0);
        chk("abort_y_valid", y_valid, 0);
        chk("abort_ram_we", ram_we, 0);
        chk("abort_ram_addr", ram_addr, 0);
        chk("abort_ram_wdata", ram_wdata, 0);
        chk("abort_overrun", overrun, 0);
        data_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reclear_cycle", {ram_we, ram_wdata, ram_addr}, {1'b1, 9'd0, 13'(i)});
            @(negedge sysclk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
